// File: rtl/sram_access_arbiter.sv
// Arbitrates the single SRAM command port between pipeline pixel reads and ADC capture writes.
// Optional statistics counters are enabled with `define SRAM_ARB_STATS_EN.
module sram_access_arbiter #(
   parameter int PRECISION       = 11,
   parameter int PIXEL_SIZE      = 16,
   parameter int ADDR_WIDTH      = 20,
   parameter int FRAME_WIDTH     = 800,
   parameter int FRAME_HEIGHT    = 600,
   parameter int SRAM_LATENCY    = 2,
   parameter int MAX_READ_STREAK = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             frozen_i,
   input  logic [2*PRECISION+PIXEL_SIZE-1:0] adc_pixel_data_i,
   input  logic                             adc_pixel_ready_i,
   output logic                             adc_pixel_read_o,
   input  logic                             request_active_i,
   input  logic [PRECISION:0]               request_x_i,
   input  logic [PRECISION:0]               request_y_i,
   output logic                             request_ready_o,
   output logic [PIXEL_SIZE-1:0]            request_data_o,
   output logic                             sram_cmd_valid_o,
   output logic                             sram_cmd_write_o,
   output logic [ADDR_WIDTH-1:0]            sram_cmd_addr_o,
   output logic [PIXEL_SIZE-1:0]            sram_cmd_wdata_o,
   input  logic [PIXEL_SIZE-1:0]            sram_rdata_i
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]                      stat_dropped_o,
   output logic [15:0]                      stat_starved_o
`endif
);

   localparam int ADC_W  = 2*PRECISION + PIXEL_SIZE;
   localparam int STRK_W = $clog2(MAX_READ_STREAK + 1);
   localparam logic [PRECISION-1:0]  FW_C = PRECISION'(FRAME_WIDTH);
   localparam logic [PRECISION-1:0]  FH_C = PRECISION'(FRAME_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] FW_A = ADDR_WIDTH'(FRAME_WIDTH);
   localparam logic [STRK_W-1:0]     STRK_MAX = STRK_W'(MAX_READ_STREAK);

   logic [PRECISION-1:0]  adc_x, adc_y;
   logic [PIXEL_SIZE-1:0] adc_pix;
   logic rd_ok, adc_in_range, wr_pend, streak_full, grant_rd, grant_wr;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

   logic                  cmd_valid_q, cmd_valid_d;
   logic                  cmd_write_q, cmd_write_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [PIXEL_SIZE-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [STRK_W-1:0]     streak_q, streak_d;
   logic [SRAM_LATENCY:0] rsp_q, rsp_d;
   logic                  rsp_ready_q, rsp_ready_d;
   logic [PIXEL_SIZE-1:0] rsp_data_q, rsp_data_d;

   assign adc_x   = adc_pixel_data_i[ADC_W-1 -: PRECISION];
   assign adc_y   = adc_pixel_data_i[PIXEL_SIZE+PRECISION-1 -: PRECISION];
   assign adc_pix = adc_pixel_data_i[PIXEL_SIZE-1:0];

   always_comb begin
      rd_ok = request_active_i & ~request_x_i[PRECISION] & ~request_y_i[PRECISION]
            & (request_x_i[PRECISION-1:0] < FW_C) & (request_y_i[PRECISION-1:0] < FH_C);
      adc_in_range = (adc_x < FW_C) & (adc_y < FH_C);
      // Out-of-range ADC words never compete for the port; they are popped alongside whatever is granted.
      wr_pend      = adc_pixel_ready_i & ~frozen_i & adc_in_range;
      streak_full  = (streak_q == STRK_MAX);
      grant_rd     = rd_ok & ~(wr_pend & streak_full);
      grant_wr     = wr_pend & ~grant_rd;
      adc_pixel_read_o = ~rst_i & adc_pixel_ready_i & (frozen_i | ~adc_in_range | grant_wr);

      rd_addr = ADDR_WIDTH'(request_y_i[PRECISION-1:0]) * FW_A
              + ADDR_WIDTH'(request_x_i[PRECISION-1:0]);
      wr_addr = ADDR_WIDTH'(adc_y) * FW_A + ADDR_WIDTH'(adc_x);

      cmd_valid_d = 1'b0;
      cmd_write_d = 1'b0;
      cmd_addr_d  = '0;
      cmd_wdata_d = '0;
      if (grant_rd) begin
         cmd_valid_d = 1'b1;
         cmd_addr_d  = rd_addr;
      end else if (grant_wr) begin
         cmd_valid_d = 1'b1;
         cmd_write_d = 1'b1;
         cmd_addr_d  = wr_addr;
         cmd_wdata_d = adc_pix;
      end

      if (!grant_rd)        streak_d = '0;
      else if (streak_full) streak_d = streak_q;
      else                  streak_d = streak_q + STRK_W'(1);

      rsp_d       = {rsp_q[SRAM_LATENCY-1:0], grant_rd};
      rsp_ready_d = rsp_q[SRAM_LATENCY];
      rsp_data_d  = rsp_q[SRAM_LATENCY] ? sram_rdata_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cmd_valid_q <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         streak_q    <= '0;
         rsp_q       <= '0;
         rsp_ready_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         streak_q    <= streak_d;
         rsp_q       <= rsp_d;
         rsp_ready_q <= rsp_ready_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign sram_cmd_valid_o = cmd_valid_q;
   assign sram_cmd_write_o = cmd_write_q;
   assign sram_cmd_addr_o  = cmd_addr_q;
   assign sram_cmd_wdata_o = cmd_wdata_q;
   assign request_ready_o  = rsp_ready_q;
   assign request_data_o   = rsp_data_q;

`ifdef SRAM_ARB_STATS_EN
   logic [15:0] dropped_q, starved_q;
   logic        drop_ev, starve_ev;

   assign drop_ev   = adc_pixel_read_o & (frozen_i | ~adc_in_range);
   assign starve_ev = rd_ok & ~grant_rd;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dropped_q <= '0;
         starved_q <= '0;
      end else begin
         if (drop_ev && dropped_q != 16'hFFFF)   dropped_q <= dropped_q + 16'd1;
         if (starve_ev && starved_q != 16'hFFFF) starved_q <= starved_q + 16'd1;
      end
   end

   assign stat_dropped_o = dropped_q;
   assign stat_starved_o = starved_q;
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed + randomized bench for sram_access_arbiter against a rule-level reference model.
module tb_sram_access_arbiter;

   logic        clk = 1'b0;
   logic        rst, frozen, adc_pixel_ready, adc_pixel_read;
   logic [37:0] adc_pixel_data;
   logic        request_active, request_ready;
   logic [11:0] request_x, request_y;
   logic [15:0] request_data, sram_cmd_wdata, sram_rdata;
   logic        sram_cmd_valid, sram_cmd_write;
   logic [19:0] sram_cmd_addr;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0] stat_dropped, stat_starved;
`endif

   always #5 clk = ~clk;

   sram_access_arbiter dut (
      .clk_i(clk), .rst_i(rst), .frozen_i(frozen),
      .adc_pixel_data_i(adc_pixel_data), .adc_pixel_ready_i(adc_pixel_ready),
      .adc_pixel_read_o(adc_pixel_read),
      .request_active_i(request_active), .request_x_i(request_x), .request_y_i(request_y),
      .request_ready_o(request_ready), .request_data_o(request_data),
      .sram_cmd_valid_o(sram_cmd_valid), .sram_cmd_write_o(sram_cmd_write),
      .sram_cmd_addr_o(sram_cmd_addr), .sram_cmd_wdata_o(sram_cmd_wdata),
      .sram_rdata_i(sram_rdata)
`ifdef SRAM_ARB_STATS_EN
      , .stat_dropped_o(stat_dropped), .stat_starved_o(stat_starved)
`endif
   );

   // SRAM core model: read data = address, two cycles after the command; junk otherwise.
   logic        h_v = 1'b0;
   logic [19:0] h_a = '0;
   always @(posedge clk) begin
      h_v        <= sram_cmd_valid && !sram_cmd_write;
      h_a        <= sram_cmd_addr;
      sram_rdata <= h_v ? h_a[15:0] : 16'($urandom);
   end

   int          n_chk = 0, n_pass = 0;
   int          cyc = 0, streak = 0, n_drop = 0, n_starv = 0;
   int          n_wr = 0;
   logic [37:0] fifo[$];
   bit          exp_rdy[8];
   logic [15:0] exp_dat[8];
   bit          exp_v, exp_w;
   logic [19:0] exp_a;
   logic [15:0] exp_d;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic logic [37:0] mkw(input int x, input int y, input logic [15:0] p);
      return {11'(x), 11'(y), p};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin exp_rdy[i] = 1'b0; exp_dat[i] = '0; end
      exp_v = 0; exp_w = 0; exp_a = '0; exp_d = '0;
      streak = 0; n_drop = 0; n_starv = 0;
   endtask

   task automatic step(input bit a, input int x, input int y, input bit frz, input bit r);
      int wx, wy, slot;
      bit rdy, rdok, inr, wrv, starve, grd, gwr, pop;
      logic [37:0] w, tmp;
      request_active = a; request_x = 12'(x); request_y = 12'(y);
      frozen = frz; rst = r;
      rdy = fifo.size() > 0;
      w   = rdy ? fifo[0] : '0;
      adc_pixel_ready = rdy; adc_pixel_data = w;
      #1;
      wx     = int'(w[37:27]);
      wy     = int'(w[26:16]);
      rdok   = a && x >= 0 && x < 800 && y >= 0 && y < 600;
      inr    = wx < 800 && wy < 600;
      wrv    = rdy && !frz && inr;
      starve = rdok && wrv && streak == 4;
      grd    = rdok && !starve;
      gwr    = wrv && !grd;
      pop    = !r && rdy && (frz || !inr || gwr);
      chk("adc_pixel_read", 32'(adc_pixel_read), 32'(pop));
      @(posedge clk);
      if (r) begin
         model_clear();
      end else begin
         if (pop) tmp = fifo.pop_front();
         exp_v = grd || gwr;
         exp_w = gwr;
         exp_a = grd ? 20'(y*800 + x) : (gwr ? 20'(wy*800 + wx) : 20'd0);
         exp_d = gwr ? w[15:0] : 16'd0;
         if (gwr) n_wr++;
         slot = (cyc + 4) % 8;
         exp_rdy[slot] = grd;
         exp_dat[slot] = grd ? 16'(y*800 + x) : 16'd0;
         streak = grd ? ((streak < 4) ? streak + 1 : 4) : 0;
         if (pop && (frz || !inr)) n_drop++;
         if (rdok && !grd) n_starv++;
      end
      cyc++;
      @(negedge clk);
      slot = cyc % 8;
      chk("cmd_valid", 32'(sram_cmd_valid), 32'(exp_v));
      chk("cmd_write", 32'(sram_cmd_write), 32'(exp_w));
      chk("cmd_addr",  32'(sram_cmd_addr),  32'(exp_a));
      chk("cmd_wdata", 32'(sram_cmd_wdata), 32'(exp_d));
      chk("req_ready", 32'(request_ready),  32'(exp_rdy[slot]));
      chk("req_data",  32'(request_data),   32'(exp_dat[slot]));
      exp_rdy[slot] = 1'b0; exp_dat[slot] = '0;
`ifdef SRAM_ARB_STATS_EN
      chk("stat_dropped", 32'(stat_dropped), 32'(n_drop));
      chk("stat_starved", 32'(stat_starved), 32'(n_starv));
`endif
   endtask

   initial begin
      int rx, ry, wr0;
      bit act, frz;
      rst = 1; frozen = 0; adc_pixel_ready = 0; adc_pixel_data = '0;
      request_active = 0; request_x = '0; request_y = '0;
      model_clear();
      @(negedge clk);

      // Reset: everything quiet.
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);

      // Reads only at (10,2): data 1610 in every slot.
      for (int i = 0; i < 10; i++) step(1, 10, 2, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

      // Continuous reads with a pending ADC stream: 4 reads then a forced write.
      for (int i = 0; i < 4; i++) fifo.push_back(mkw(100 + i, 50, 16'h1230 + 16'(i)));
      wr0 = n_wr;
      for (int i = 0; i < 20; i++) step(1, 20 + i, 3, 0, 0);
      chk("writes_forced", 32'(n_wr - wr0), 32'd4);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

      // Out-of-range reads never reach the SRAM.
      step(1, -1, 5, 0, 0);
      step(1, 5, 600, 0, 0);
      step(1, 800, 0, 0, 0);
      step(1, 799, 599, 0, 0);
      step(1, 0, -1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

      // Frozen: eight words discarded.
      for (int i = 0; i < 8; i++) fifo.push_back(mkw(i, i, 16'hAA00 + 16'(i)));
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
      chk("fifo_drained", 32'(fifo.size()), 32'd0);

      // Corner pixel write and an out-of-range ADC word alongside a read.
      fifo.push_back(mkw(799, 599, 16'hF800));
      step(0, 0, 0, 0, 0);
      fifo.push_back(mkw(800, 10, 16'h0BAD));
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

      // Reset two cycles after three read grants flushes the in-flight responses.
      step(1, 7, 7, 0, 0);
      step(1, 8, 7, 0, 0);
      step(1, 9, 7, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

      // Randomized traffic.
      frz = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 1 && fifo.size() < 12) begin
            if ($urandom_range(0, 9) == 0)
               fifo.push_back(mkw($urandom_range(780, 2047), $urandom_range(0, 700), 16'($urandom)));
            else
               fifo.push_back(mkw($urandom_range(0, 799), $urandom_range(0, 599), 16'($urandom)));
         end
         if ($urandom_range(0, 15) == 0) frz = !frz;
         act = $urandom_range(0, 3) != 0;
         rx  = int'($urandom_range(0, 900)) - 50;
         ry  = int'($urandom_range(0, 650)) - 20;
         step(act, rx, ry, frz, $urandom_range(0, 79) == 0);
      end
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
